// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding, count type and clamp helpers for the soft-start PWM
package pwm_pkg;

  localparam int          PWM_CNT_WIDTH = 16;
  localparam logic [31:0] MIN_PERIOD    = 32'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } pwm_state_e;

  typedef logic [PWM_CNT_WIDTH-1:0] pwm_cnt_t;

  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // A period shorter than two cycles has no room for both a high and a low phase.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return umax(p, MIN_PERIOD);
  endfunction

  function automatic logic [31:0] clamp_duty(input logic [31:0] d, input logic [31:0] p);
    return umin(d, clamp_period(p));
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// rtl/pwm_shadow_reg.sv - one-deep shadow register for period/duty with valid/ready handshake.
// Values are clamped on capture; the owner clears pending by strobing apply_i.
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH      = PWM_CNT_WIDTH,
  parameter int DEFAULT_PERIOD = 100,
  parameter int DEFAULT_DUTY   = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  input  logic                 apply_i,
  output logic                 pending_o,
  output logic [CNT_WIDTH-1:0] shadow_period_o,
  output logic [CNT_WIDTH-1:0] shadow_duty_o
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(clamp_period(DEFAULT_PERIOD));
  localparam logic [CNT_WIDTH-1:0] RST_DUTY   = CNT_WIDTH'(clamp_duty(DEFAULT_DUTY, DEFAULT_PERIOD));

  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic                 xfer;

  assign xfer = cfg_valid && !pending_q;

  always_comb begin
    pending_d = pending_q;
    period_d  = period_q;
    duty_d    = duty_q;
    if (xfer) begin
      period_d  = CNT_WIDTH'(clamp_period(32'(cfg_period)));
      duty_d    = CNT_WIDTH'(clamp_duty(32'(cfg_duty), 32'(cfg_period)));
      pending_d = 1'b1;
    end else if (apply_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      period_q  <= RST_PERIOD;
      duty_q    <= RST_DUTY;
    end else begin
      pending_q <= pending_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
    end
  end

  assign cfg_ready       = !pending_q;
  assign pending_o       = pending_q;
  assign shadow_period_o = period_q;
  assign shadow_duty_o   = duty_q;

endmodule

// File: rtl/pwm_softstart_gen.sv
// rtl/pwm_softstart_gen.sv - counter PWM gate drive with boundary-aligned shadow updates
// and a soft-start duty ramp after enable.
module pwm_softstart_gen
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH      = PWM_CNT_WIDTH,
  parameter int DEFAULT_PERIOD = 100,
  parameter int DEFAULT_DUTY   = 50,
  parameter int SS_STEP        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  output logic                 ctrl,
  output logic                 period_start,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] duty_active
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(clamp_period(DEFAULT_PERIOD));
  localparam logic [CNT_WIDTH-1:0] RST_DUTY   = CNT_WIDTH'(clamp_duty(DEFAULT_DUTY, DEFAULT_PERIOD));
  localparam logic [CNT_WIDTH:0]   STEP_EXT   = (CNT_WIDTH+1)'(SS_STEP);

  pwm_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] target_q, target_d;
  logic                 ctrl_q, ctrl_d;
  logic                 pstart_q, pstart_d;

  logic                 pending;
  logic                 apply;
  logic [CNT_WIDTH-1:0] sh_period, sh_duty;

  logic                 running;
  logic                 boundary;
  logic [CNT_WIDTH-1:0] per_eff, tgt_eff;
  logic [CNT_WIDTH:0]   ramp_sum;
  logic [CNT_WIDTH-1:0] ramp_next;
  logic [CNT_WIDTH-1:0] start_duty;

  pwm_shadow_reg #(
    .CNT_WIDTH     (CNT_WIDTH),
    .DEFAULT_PERIOD(DEFAULT_PERIOD),
    .DEFAULT_DUTY  (DEFAULT_DUTY)
  ) u_shadow (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .apply_i        (apply),
    .pending_o      (pending),
    .shadow_period_o(sh_period),
    .shadow_duty_o  (sh_duty)
  );

  assign running  = (state_q != IDLE);
  assign boundary = running && (cnt_q == period_q - CNT_WIDTH'(1));

  // While idle there is no waveform to tear, so a pending update lands immediately.
  assign apply   = pending && (!running || boundary);
  assign per_eff = apply ? sh_period : period_q;
  assign tgt_eff = apply ? sh_duty : target_q;

  // Ramp sum carries one extra bit so a near-full-scale duty cannot wrap before saturating.
  assign ramp_sum   = {1'b0, duty_q} + STEP_EXT;
  assign ramp_next  = (ramp_sum >= {1'b0, tgt_eff}) ? tgt_eff : ramp_sum[CNT_WIDTH-1:0];
  assign start_duty = CNT_WIDTH'(umin(SS_STEP, 32'(tgt_eff)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (tgt_eff == '0) ? RUN : RAMP;
        RAMP:    if (boundary && (ramp_next == tgt_eff)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = '0;
    duty_d   = '0;
    period_d = per_eff;
    target_d = tgt_eff;
    // Gating with en gives a safe stop one cycle after enable falls, mid-period or not.
    ctrl_d   = en && running && (cnt_q < duty_q);
    pstart_d = running && (cnt_q == '0);
    if (en) begin
      case (state_q)
        IDLE: begin
          duty_d = start_duty;
        end
        RAMP: begin
          cnt_d  = boundary ? '0 : cnt_q + CNT_WIDTH'(1);
          duty_d = boundary ? ramp_next : duty_q;
        end
        RUN: begin
          cnt_d  = boundary ? '0 : cnt_q + CNT_WIDTH'(1);
          duty_d = boundary ? tgt_eff : duty_q;
        end
        default: begin
          cnt_d  = '0;
          duty_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      duty_q   <= '0;
      period_q <= RST_PERIOD;
      target_q <= RST_DUTY;
      ctrl_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      target_q <= target_d;
      ctrl_q   <= ctrl_d;
      pstart_q <= pstart_d;
    end
  end

  assign ctrl         = ctrl_q;
  assign period_start = pstart_q;
  assign state        = state_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_softstart_gen.sv
// tb/tb_pwm_softstart_gen.sv - scoreboard bench for pwm_softstart_gen with a behavioural reference model
module tb_pwm_softstart_gen;

  localparam int W        = 16;
  localparam int DEF_P    = 100;
  localparam int DEF_D    = 50;
  localparam int STEP     = 4;
  localparam int MAX_FAIL = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         cfg_ready;
  logic         ctrl;
  logic         period_start;
  logic [1:0]   state;
  logic [W-1:0] duty_active;

  pwm_softstart_gen #(
    .CNT_WIDTH     (W),
    .DEFAULT_PERIOD(DEF_P),
    .DEFAULT_DUTY  (DEF_D),
    .SS_STEP       (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .ctrl        (ctrl),
    .period_start(period_start),
    .state       (state),
    .duty_active (duty_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ctrl;
    logic         ps;
    logic [1:0]   st;
    logic [W-1:0] duty;
    logic         rdy;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0/1/2 = idle/ramping/running, pos = place within the current period.
  int m_mode, m_pos, m_period, m_target, m_level, m_sh_p, m_sh_d;
  bit m_ctrl, m_ps, m_pend;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_level = 0;
    m_period = DEF_P; m_target = imin(DEF_D, DEF_P);
    m_sh_p = DEF_P; m_sh_d = imin(DEF_D, DEF_P);
    m_ctrl = 0; m_ps = 0; m_pend = 0;
  endtask

  task automatic model_advance(input bit e, input bit v, input int cp, input int cd);
    bit running, at_end, take;
    int np, nt;
    running = (m_mode != 0);
    at_end  = running && (m_pos == m_period - 1);
    take    = m_pend && (!running || at_end);
    np = take ? m_sh_p : m_period;
    nt = take ? m_sh_d : m_target;
    m_ctrl = e && running && (m_pos < m_level);
    m_ps   = running && (m_pos == 0);
    if (!e) begin
      m_mode = 0; m_pos = 0; m_level = 0;
    end else if (!running) begin
      m_pos = 0;
      m_level = imin(STEP, nt);
      m_mode = (nt == 0) ? 2 : 1;
    end else begin
      m_pos = at_end ? 0 : m_pos + 1;
      if (at_end) begin
        if (m_mode == 1) begin
          m_level = imin(m_level + STEP, nt);
          if (m_level == nt) m_mode = 2;
        end else begin
          m_level = nt;
        end
      end
    end
    m_period = np;
    m_target = nt;
    if (take) begin
      m_pend = 0;
    end else if (v && !m_pend) begin
      m_sh_p = imax(cp, 2);
      m_sh_d = imin(cd, m_sh_p);
      m_pend = 1;
    end
  endtask

  task automatic push_exp();
    obs_t o;
    o.ctrl = m_ctrl;
    o.ps   = m_ps;
    o.st   = 2'(m_mode);
    o.duty = W'(m_level);
    o.rdy  = !m_pend;
    exp_q.push_back(o);
  endtask

  // Inputs change 1 time unit after the edge; an asserted rst takes effect at once.
  task automatic step(input bit r, input bit e, input bit v, input int cp, input int cd);
    @(posedge clk);
    #1;
    rst = r; en = e; cfg_valid = v;
    cfg_period = W'(cp); cfg_duty = W'(cd);
    if (r) model_reset();
    push_exp();
    if (!r) model_advance(e, v, cp, cd);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(0, e, 0, 0, 0);
  endtask

  task automatic send(input int p, input int d);
    step(0, 1, 1, p, d);
  endtask

  function automatic bit cond(input int k);
    case (k)
      0:       return m_mode == 2;
      1:       return m_mode == 2 && m_pos == 20;
      2:       return !m_pend;
      3:       return m_mode == 1 && m_level == 20;
      default: return m_mode != 0 && m_ctrl && m_pos == 3;
    endcase
  endfunction

  task automatic wait_for(input int k, input int budget, input string name);
    for (int i = 0; i < budget && !cond(k); i++) step(0, 1, 0, 0, 0);
    n_cmp++;
    if (!cond(k)) begin
      n_bad++;
      $display("FAIL wait_%s: condition not reached, required within %0d cycles", name, budget);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    forever begin
      obs_t e;
      obs_t a;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ctrl, period_start, state, duty_active, cfg_ready};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: actual ctrl=%0b ps=%0b state=%0d duty=%0d ready=%0b required ctrl=%0b ps=%0b state=%0d duty=%0d ready=%0b",
                   $time, a.ctrl, a.ps, a.st, a.duty, a.rdy, e.ctrl, e.ps, e.st, e.duty, e.rdy);
          if (n_bad >= MAX_FAIL) summary();
        end
      end
    end
  end

  initial begin
    bit e_r;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Defaults: soft start from reset into RUN, then steady 50/100.
    step(0, 1, 0, 0, 0);
    wait_for(0, 3000, "ramp_to_run");
    run(250, 1);

    // Shadow update mid-period, applied at the next boundary.
    wait_for(1, 300, "run_cnt20");
    send(40, 10);
    run(300, 1);

    // Clamp: period 1 becomes 2, duty 9 becomes 2.
    wait_for(2, 300, "clamp_ready");
    send(1, 9);
    run(100, 1);

    // Zero duty keeps ctrl low while period_start still pulses.
    wait_for(2, 300, "zero_ready");
    send(20, 0);
    run(100, 1);

    // Duty equal to period holds ctrl high.
    wait_for(2, 300, "full_ready");
    send(10, 10);
    run(60, 1);

    // Enable drop during the high phase, then restart the soft start.
    wait_for(4, 300, "high_phase");
    run(5, 0);
    run(100, 1);

    // Ramp interrupted by a lower duty target.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    wait_for(3, 1000, "ramp_at_20");
    send(100, 12);
    wait_for(2, 300, "ramp_apply");
    run(250, 1);

    // Asynchronous reset between edges with an update still pending.
    wait_for(1, 300, "pre_async");
    send(60, 30);
    run(5, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    run(300, 1);

    // Randomized enable, config and occasional reset traffic.
    e_r = 1;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit v;
      if ($urandom_range(0, 299) == 0) e_r = !e_r;
      r = ($urandom_range(0, 1999) == 0);
      v = ($urandom_range(0, 39) == 0);
      step(r, e_r, v, int'($urandom_range(0, 60)), int'($urandom_range(0, 70)));
    end
    run(20, 1);

    @(negedge clk);
    #1;
    summary();
  end

endmodule

// File: doc/pwm_softstart_gen.md
Name: pwm_softstart_gen

Overview:
Digital gate-drive generator that produces the 1-bit ctrl signal feeding the switched filter stage in emulation. It replaces the fixed-duty PWM macro with a counter-based PWM that has runtime-programmable period and duty. It supports glitch-free shadow-register updates at period boundaries and a soft-start duty ramp so the filter is not hit with a full-duty step at enable.

Parameters:
CNT_WIDTH, 16, width of period/duty counters (clk cycles)
DEFAULT_PERIOD, 100, period_active after reset (cycles, must be >= 2)
DEFAULT_DUTY, 50, duty_target after reset (cycles)
SS_STEP, 1, duty increment per period during soft start (cycles, >= 1)

Ports:
clk  input  1  emulator clock
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; level sensitive
cfg_valid  input  1  new period/duty offered
cfg_ready  output  1  shadow register free; transfer when cfg_valid && cfg_ready
cfg_period  input  CNT_WIDTH  requested period in cycles
cfg_duty  input  CNT_WIDTH  requested high time in cycles
ctrl  output  1  gate drive to filter, registered
period_start  output  1  one-cycle pulse coincident with first ctrl cycle of each period
state  output  2  0=IDLE, 1=RAMP, 2=RUN
duty_active  output  CNT_WIDTH  duty currently applied

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, ctrl=0, period_start=0, duty_active=0, cfg_ready=1, pending=0, period_active=DEFAULT_PERIOD, duty_target=min(DEFAULT_DUTY, DEFAULT_PERIOD). Reset mid-period aborts immediately; no completion.
- Counter: cnt runs 0..period_active-1 and then wraps to 0 while state != IDLE. Boundary = cycle where cnt == period_active-1.
- Output: ctrl(t+1) = (state(t) != IDLE) && (cnt(t) < duty_active(t)). period_start(t+1) = (state(t) != IDLE) && cnt(t) == 0. Latency is 1 cycle from counter to pins.
- Config handshake: cfg_ready = !pending. On transfer, shadow <= {max(cfg_period,2), min(cfg_duty, max(cfg_period,2))} and pending <= 1.
- Apply rule:
  - In IDLE, a pending shadow is applied on the next cycle.
  - Otherwise it is applied only on a boundary cycle, becoming effective for the period starting next cycle. pending clears in the same cycle.
  - Transfer and apply in the same cycle is impossible, because cfg_ready=0 while pending.
- FSM:
  - IDLE: cnt=0. When en=1, go to RAMP, cnt=0, duty_active=min(SS_STEP, duty_target). If duty_target==0, go directly to RUN.
  - RAMP: on each boundary, duty_active <= min(duty_active+SS_STEP, duty_target). Go to RUN on the boundary where the result equals duty_target. If an applied shadow gives duty_target <= duty_active, then duty_active <= duty_target and the state goes to RUN.
  - RUN: on each boundary, duty_active <= duty_target (after any shadow apply).
  - Any state with en=0: next cycle state=IDLE, cnt=0, duty_active=0. ctrl is 0 from the cycle after en falls (immediate safe stop, no period completion). pending is retained.
- Arithmetic: the duty_active+SS_STEP sum is computed at CNT_WIDTH+1 bits, then saturated. Comparisons are unsigned.
- Boundaries:
  - duty_target == period_active gives ctrl constantly 1 in RUN.
  - duty 0 gives ctrl constantly 0; period_start still pulses.
  - Period shrink takes effect only at a boundary, so cnt never exceeds the old period.

Decomposition:
- Package pwm_pkg: state enum (IDLE/RAMP/RUN), CNT_WIDTH-typed count typedef, clamp/saturate functions.
- Sub-module pwm_shadow_reg: handshake, clamp, and the pending flag. Exposes shadow values, pending, and an apply strobe input.
- The top module holds the FSM, counter, and output registers.

Test Plan:
- Reset defaults: rst pulse, en=1, no cfg -> RAMP. duty_active goes 1,2,...,50 over 50 periods of 100 cycles, then state=RUN. ctrl high 50 of each 100 cycles. period_start every 100 cycles.
- Shadow update: in RUN, send cfg_period=40, cfg_duty=10 at cnt=20 -> cfg_ready drops. Current period completes at 100 cycles. The next period is 40 cycles with ctrl high 10. cfg_ready returns 1 on the apply cycle.
- Clamp: cfg_period=1, cfg_duty=9 -> applied period 2, duty 2. ctrl constantly 1 and period_start every 2 cycles.
- Ramp interrupted: SS_STEP=4, duty_target=50. During RAMP at duty_active=20, apply cfg_duty=12 -> next period duty_active=12, state=RUN.
- Enable drop: en=0 mid-high-phase -> ctrl=0 within 1 cycle and state=IDLE. Re-assert en -> soft-start restarts from SS_STEP.
- Async reset mid-period: rst asserted between clock edges -> ctrl, period_start, and state clear without waiting for clk. pending is cleared and cfg_ready=1.
